seq_mul32: RTL
==============

SEQ_MUL32 -- requirements
Module: seq_mul32

Interface
REQ-001 The module SHALL have no parameters; operand width is fixed at 32, product width at 64.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start_valid  input  1  operands a/b are valid this cycle.
REQ-005 start_ready  output  1  block can accept operands (high only in IDLE).
REQ-006 a  input  32  unsigned multiplicand, sampled on the accept edge.
REQ-007 b  input  32  unsigned multiplier, sampled on the accept edge.
REQ-008 done_valid  output  1  product is valid (high only in DONE).
REQ-009 done_ready  input  1  consumer accepts the product.
REQ-010 product  output  64  unsigned a*b, stable while done_valid=1.
REQ-011 busy  output  1  high in RUN or DONE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE: start_valid&start_ready SHALL latch mcand=a, mplr=b, acc_hi=0, count=0, then move to RUN.
REQ-014 RUN, each edge: {carry,sum} = acc_hi + (mplr[0] ? mcand : 0); acc_hi <= {carry,sum[31:1]}; mplr <= {sum[0],mplr[31:1]}; count <= count+1.
REQ-015 The add SHALL use a 33-bit result: carry-in 0, carry-out as bit 32; no overflow is possible.
REQ-016 On the RUN edge where count=31, the block SHALL complete the iteration, load product={acc_hi,mplr} (post-shift) and move to DONE.
REQ-017 Base latency SHALL be exactly 32 edges from the accept edge to done_valid first high, independent of operand values.
REQ-018 DONE: done_valid=1, product held; done_valid&done_ready SHALL return the block to IDLE on that edge.
REQ-019 start_valid outside IDLE SHALL be ignored (no queuing, no corruption); a new operation SHALL be accepted no earlier than the edge after the DONE handshake.
REQ-020 done_ready outside DONE SHALL have no effect.
REQ-021 product SHALL retain its last value in IDLE and RUN until the next DONE load.

Reset
REQ-022 reset=1 SHALL, at the next edge and regardless of state, force IDLE, start_ready=1, done_valid=0, busy=0, product=0, and clear acc_hi, mplr, mcand and count.
REQ-023 Reset mid-RUN or in DONE SHALL abort the operation with no done_valid pulse; reset has priority over every handshake in the same cycle.

Configuration
REQ-024 Macro SEQ_MUL32_EARLY_EXIT_EN: when defined, any RUN edge on which all unconsumed multiplier bits (mplr bits 0..31-count) are zero SHALL load product={acc_hi,mplr}>>(32-count) and move to DONE.
REQ-025 With SEQ_MUL32_EARLY_EXIT_EN, latency SHALL be 1 for b=0 and min(32, h+2) otherwise, where h is the index of the highest set bit of b.
REQ-026 Without SEQ_MUL32_EARLY_EXIT_EN, latency SHALL always be 32; product values SHALL be identical in both builds.

Structure
REQ-027 Package seq_mul32_pkg SHALL hold the state enumeration (IDLE/RUN/DONE), OP_W=32, PROD_W=64 and CNT_W=6.
REQ-028 The 32-bit add SHALL be a single instance of the team's 32-bit ripple-carry adder sub-module (RCA32), with cin tied to 0 and cout used as bit 32; all sequencing stays in seq_mul32.

Verification
REQ-029 Accept a=3, b=5 with done_ready=1 -> done_valid high 32 edges after accept, product=15, IDLE one edge later.
REQ-030 Accept a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFE00000001.
REQ-031 Accept a=0x12345678, b=0x9ABCDEF0; hold done_ready=0 for 10 cycles in DONE -> product=0x0B00EA4E242D2080 stable throughout, start_ready=0 throughout.
REQ-032 Pulse start_valid with a=7, b=7 while in RUN -> ignored; the in-flight product of 3*5=15 is unaffected.
REQ-033 Assert reset on the 10th RUN edge -> IDLE, product=0, no done_valid pulse; the next op 2*2 gives 4.
REQ-034 Accept a=9, b=0 -> done_valid after 1 edge with SEQ_MUL32_EARLY_EXIT_EN, 32 edges without; product=0 in both builds. Accept a=9, b=1 -> 2 edges with the macro, product=9.

Source files
------------

// File: rtl/seq_mul32_pkg.sv
// seq_mul32_pkg: shared widths and FSM state encoding for the sequential multiplier.
package seq_mul32_pkg;
  localparam int OP_W = 32;
  localparam int PROD_W = 64;
  localparam int CNT_W = 6;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/seq_mul32_rca32.sv
// seq_mul32_rca32: 32-bit ripple-carry adder with carry-in and carry-out.
import seq_mul32_pkg::*;
module seq_mul32_rca32 (
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  logic            cin,
  output logic [OP_W-1:0] sum,
  output logic            cout
);
  logic [OP_W:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < OP_W; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[OP_W];
endmodule

// File: rtl/seq_mul32.sv
// seq_mul32: shift-add 32x32 unsigned multiplier, one multiplier bit per cycle.
// Optional SEQ_MUL32_EARLY_EXIT_EN finishes once the remaining multiplier bits are all zero.
import seq_mul32_pkg::*;
module seq_mul32 (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              done_valid,
  input  logic              done_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy
);
  state_t state, state_n;
  logic [OP_W-1:0] mcand, mplr, acc_hi, sum, next_acc, next_mplr;
  logic [CNT_W-1:0] count;
  logic [PROD_W-1:0] load_val;
  logic cout, early, finish;
  seq_mul32_rca32 u_rca32 (
    .a(acc_hi),
    .b(mplr[0] ? mcand : '0),
    .cin(1'b0),
    .sum(sum),
    .cout(cout)
  );
  assign next_acc = {cout, sum[OP_W-1:1]};
  assign next_mplr = {sum[0], mplr[OP_W-1:1]};
`ifdef SEQ_MUL32_EARLY_EXIT_EN
  // Consumed multiplier bits sit at the top of mplr; shift them down to align the partial product.
  assign early = (mplr & ({OP_W{1'b1}} >> count)) == '0;
  assign load_val = early ? {acc_hi, mplr} >> (7'd32 - {1'b0, count}) : {next_acc, next_mplr};
`else
  assign early = 1'b0;
  assign load_val = {next_acc, next_mplr};
`endif
  assign start_ready = state == IDLE;
  assign done_valid = state == DONE;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    finish = 1'b0;
    state_n = state;
    finish = (state == RUN) && (count == 6'd31 || early);
    state_n = state == IDLE ? (start_valid ? RUN : IDLE) :
              state == RUN  ? (finish ? DONE : RUN) :
              (done_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand <= '0;
      mplr <= '0;
      acc_hi <= '0;
      count <= '0;
      product <= '0;
    end else if (state == IDLE && start_valid) begin
      mcand <= a;
      mplr <= b;
      acc_hi <= '0;
      count <= '0;
    end else if (state == RUN) begin
      acc_hi <= next_acc;
      mplr <= next_mplr;
      count <= count + 1'b1;
      if (finish) product <= load_val;
    end
  end
endmodule
